// File: rtl/fsk_phase_gen.sv
// Continuous-phase FSK phase generator: one data bit in, SAMPLES_PER_BIT phase
// samples out, phase carried across bit boundaries without discontinuity.
module fsk_phase_gen #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tw_mark,
  input  logic [31:0] tw_space,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic        phase_clr,
  output logic [31:0] phase_out,
  output logic        phase_valid,
  output logic        bit_strobe,
  output logic        busy,
  output logic        state_dbg
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_BIT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   tw_cur;
  logic          last_sample;
  logic          accept;

  // Handshake: a bit transfers on any rising edge where bit_valid and bit_ready
  // are both high; bit_ready is combinational from state so the next bit can be
  // taken on the edge that produces the last sample of the current one.
  assign last_sample = (state == SEND) && (cnt == LAST);
  assign bit_ready   = (state == IDLE) || last_sample;
  assign accept      = bit_valid && bit_ready;
  assign busy        = (state == SEND);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tw_cur      <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      bit_strobe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase_valid <= 1'b0;
          bit_strobe  <= 1'b0;
          if (accept) begin
            tw_cur <= bit_in ? tw_mark : tw_space;
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          phase_out   <= phase_out + tw_cur;
          phase_valid <= 1'b1;
          cnt         <= cnt + CW'(1);
          bit_strobe  <= last_sample;
          if (last_sample) begin
            if (bit_valid) begin
              tw_cur <= bit_in ? tw_mark : tw_space;
              cnt    <= '0;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Clear wins over this edge's accumulation; sequencing is untouched.
      if (phase_clr) phase_out <= '0;
    end
  end

endmodule

// File: tb/tb_fsk_phase_gen.sv
// Bench for fsk_phase_gen: directed scenarios plus random traffic, checked
// against a per-sample expected-step queue model.
module tb_fsk_phase_gen;

  localparam int SPB = 4;

  logic        clk;
  logic        reset;
  logic [31:0] tw_mark;
  logic [31:0] tw_space;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        phase_clr;
  logic [31:0] phase_out;
  logic        phase_valid;
  logic        bit_strobe;
  logic        busy;
  logic        state_dbg;

  int errors = 0;
  int checks = 0;

  // Model: each queued entry is the tuning word for one future sample.
  logic [31:0] exp_q[$];
  logic        last_q[$];
  logic [31:0] m_phase;
  logic        m_valid;
  logic        m_strobe;

  fsk_phase_gen #(.SAMPLES_PER_BIT(SPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tw_mark    (tw_mark),
    .tw_space   (tw_space),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .phase_clr  (phase_clr),
    .phase_out  (phase_out),
    .phase_valid(phase_valid),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_q.delete();
    m_phase  = '0;
    m_valid  = 1'b0;
    m_strobe = 1'b0;
  endtask

  task automatic check_all();
    chk("phase_out", phase_out, m_phase);
    chk("phase_valid", 32'(phase_valid), 32'(m_valid));
    chk("bit_strobe", 32'(bit_strobe), 32'(m_strobe));
    chk("busy", 32'(busy), 32'(exp_q.size() > 0));
    chk("bit_ready", 32'(bit_ready), 32'(exp_q.size() <= 1));
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic v, input logic b, input logic clr);
    logic        acc;
    logic [31:0] tw;
    bit_valid = v;
    bit_in    = b;
    phase_clr = clr;
    acc = v && (exp_q.size() <= 1);
    tw  = b ? tw_mark : tw_space;
    @(posedge clk);
    if (exp_q.size() > 0) begin
      m_phase  = m_phase + exp_q.pop_front();
      m_valid  = 1'b1;
      m_strobe = last_q.pop_front();
    end else begin
      m_valid  = 1'b0;
      m_strobe = 1'b0;
    end
    if (clr) m_phase = '0;
    if (acc) begin
      for (int i = 0; i < SPB; i++) begin
        exp_q.push_back(tw);
        last_q.push_back(i == SPB - 1);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    tw_mark   = 32'h1000_0000;
    tw_space  = 32'h0800_0000;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    phase_clr = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    @(negedge clk);
    check_all();

    // Single mark bit, then idle holding the last phase
    cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(6);
    chk("s1_hold", phase_out, 32'h4000_0000);

    // Clear in IDLE
    cycle(1'b0, 1'b0, 1'b1);
    chk("clr_idle", phase_out, 32'h0);

    // Mark then space back-to-back
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(5);
    chk("s2_end", phase_out, 32'h6000_0000);

    // Wrap
    cycle(1'b0, 1'b0, 1'b1);
    tw_mark = 32'hC000_0000;
    cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(5);
    chk("wrap_end", phase_out, 32'h0);

    // Tuning-word change mid-bit
    tw_mark = 32'h1000_0000;
    cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(2);
    tw_mark = 32'h0100_0000;
    idle_cycles(3);
    chk("twchg_bit1", phase_out, 32'h4000_0000);
    cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(5);
    chk("twchg_bit2", phase_out, 32'h4400_0000);

    // Asynchronous reset mid-bit
    tw_mark = 32'h1000_0000;
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(2);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_phase", phase_out, 32'h0);
    chk("arst_valid", 32'(phase_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("arst_first", phase_out, 32'h0800_0000);
    idle_cycles(4);

    // Clear during SEND
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("clr_send", phase_out, 32'h0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("clr_resume", phase_out, 32'h1000_0000);
    idle_cycles(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tw_mark = $urandom;
      if ($urandom_range(0, 3) == 0) tw_space = $urandom;
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0);
    end
    idle_cycles(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsk_phase_gen.md
# fsk_phase_gen

Continuous-phase FSK phase generator for the modulator path. Accepts one data bit at a time over a valid/ready handshake, selects the mark or space tuning word, and advances a 32-bit phase accumulator for exactly SAMPLES_PER_BIT clocks per bit. The 32-bit phase word feeds the downstream 32-bit pipeline register ahead of the sine lookup. The phase is never reset between bits, so the output carries no phase discontinuity at bit boundaries.

## Interface
- SAMPLES_PER_BIT, 16: phase samples generated per bit. Must be ≥ 2.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it low clears all state immediately; release is synchronous to clk.
- tw_mark  in  32  tuning word for bit 1. Sampled only when a bit is accepted.
- tw_space  in  32  tuning word for bit 0. Sampled only when a bit is accepted.
- bit_in  in  1  data bit; qualified by bit_valid.
- bit_valid  in  1  upstream has a bit.
- bit_ready  out  1  combinational; the block can accept a bit this cycle.
- phase_clr  in  1  synchronous clear of the phase accumulator.
- phase_out  out  32  phase accumulator value, registered.
- phase_valid  out  1  phase_out holds a new sample this cycle.
- bit_strobe  out  1  one-cycle pulse, coincident with the last sample of each bit.
- busy  out  1  high while in SEND.

## Operation
- States:
  - IDLE: no bit loaded.
  - SEND: generating samples for the loaded bit.
  - Internal registers: tw_cur[31:0], cnt (ceil(log2(SAMPLES_PER_BIT)) bits).
- bit_ready = (state==IDLE) or (state==SEND and cnt==SAMPLES_PER_BIT-1).
- Accept: bit_valid and bit_ready are both high at a rising edge.
  - tw_cur <= bit_in ? tw_mark : tw_space.
  - cnt <= 0.
  - state <= SEND.
- SEND, every edge:
  - phase_out <= phase_out + tw_cur, modulo 2^32; carry discarded, natural wrap.
  - phase_valid <= 1.
  - cnt <= cnt + 1.
- SEND edge with cnt==SAMPLES_PER_BIT-1:
  - The accumulation still happens.
  - bit_strobe <= 1.
  - If bit_valid is high, the next bit is accepted as above and state stays SEND. There is no gap between bits.
  - Otherwise state <= IDLE.
- IDLE, every edge:
  - phase_out holds its value.
  - phase_valid <= 0.
  - bit_strobe <= 0.
- phase_clr high at an edge: phase_out <= 0. This takes precedence over accumulation on that edge. State, cnt and phase_valid are unaffected.
- Tuning-word input changes during a bit are ignored until the next accept.
- Reset values:
  - state = IDLE, cnt = 0, tw_cur = 0.
  - phase_out = 0, phase_valid = 0, bit_strobe = 0, busy = 0.
  - bit_ready = 1, which follows from IDLE.
- Reset asserted mid-bit: the in-flight bit is dropped, with no partial completion and no strobe.

## Timing
- If a bit is accepted at edge k, its samples are produced at edges k+1 … k+SAMPLES_PER_BIT.
- Each sample is visible on phase_out, with phase_valid high, in the cycle following its edge.
- Each bit produces exactly SAMPLES_PER_BIT valid samples.
- bit_strobe is high in the same cycle as the last sample of each bit.
- With bit_valid held high continuously, phase_valid stays high continuously.
- Throughput: one bit per SAMPLES_PER_BIT clocks.

## Test plan
All scenarios use SAMPLES_PER_BIT=4, tw_mark=0x1000_0000 and tw_space=0x0800_0000 unless stated otherwise.
- Reset release, then one bit=1 accepted at edge k with bit_valid dropped afterwards:
  - phase_out = 0x10000000, 0x20000000, 0x30000000, 0x40000000 with phase_valid high for 4 cycles.
  - bit_strobe high only in the cycle showing 0x40000000.
  - Then IDLE, phase_out holds 0x40000000, and bit_ready=1.
- Bits 1 then 0 with bit_valid held high:
  - 8 consecutive valid samples: 0x1…0x4 ×2^28, then 0x48000000, 0x50000000, 0x58000000, 0x60000000.
  - Two strobes, no gap between bits.
- Wrap, with tw_mark=0xC000_0000 and one bit=1:
  - phase_out = 0xC0000000, 0x80000000, 0x40000000, 0x00000000. No error condition.
- tw_mark changed to 0x0100_0000 after the 2nd sample of a mark bit:
  - The remaining samples still step by 0x10000000.
  - The next accepted mark bit steps by 0x01000000.
- reset pulled low after the 2nd sample of a bit:
  - phase_out, phase_valid and busy go to 0 immediately, without waiting for a clock edge.
  - After release: bit_ready=1, and the next bit=0 yields 0x08000000 as its first sample.
- phase_clr pulsed in IDLE with phase_out=0x40000000:
  - phase_out=0 after the edge and phase_valid stays 0.
  - phase_clr pulsed during SEND forces 0 on that edge; accumulation resumes from 0 on the following edge.
